sync_fifo_gen2: RTL and testbench
=================================

Name: sync_fifo_gen2

Overview:
Second-generation parametrised synchronous FIFO for single-clock datapaths.
- Uses all DEPTH entries, using an extra pointer bit to tell full from empty.
- Supports standard or first-word-fall-through (FWFT) read mode.
- Accepts a write when full if a read is accepted in the same cycle.
- Overflow/underflow error flags are sticky and cleared by a synchronous flush.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
DEPTH, 32, number of storage entries; power of two, >=4
FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
NEAR_E, 2, near_empty asserted when 1 <= count <= NEAR_E
NEAR_F, 2, near_full asserted when DEPTH-NEAR_F <= count <= DEPTH-1
Derived: AW = $clog2(DEPTH), CW = AW+1.

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset, asynchronous assert, active-low
data_in  input  WIDTH  write data
wr_en  input  1  write request
rd_en  input  1  read request (FWFT: pop/acknowledge of current head)
flush  input  1  synchronous clear of contents and sticky flags
data_out  output  WIDTH  read data
valid  output  1  data_out holds a valid word (meaning depends on mode)
count  output  CW  number of stored words, 0..DEPTH
full  output  1  count == DEPTH
near_full  output  1  count in [DEPTH-NEAR_F, DEPTH-1]
empty  output  1  count == 0
near_empty  output  1  count in [1, NEAR_E]
overflow  output  1  sticky: write was rejected
underflow  output  1  sticky: read was rejected

Behaviour:
Reset and flush:
- rst low (async): wr_ptr=rd_ptr=0, count=0, data_out=0, valid=0, overflow=0, underflow=0. Storage array is not cleared; it must remain RAM-inferable.
- flush=1 at a clock edge: same clear as reset. flush dominates wr_en/rd_en that cycle; no words are accepted or popped and no error flags are set.
Accept rules, evaluated on pre-edge state:
- rd_acc = rd_en & !empty.
- wr_acc = wr_en & (!full | rd_acc).
- No bypass when empty: a read while empty is rejected even with a simultaneous write. The write is still accepted.
Pointer and count updates:
- Pointers are CW bits and wrap modulo 2*DEPTH. Memory is indexed by the low AW bits.
- count = wr_ptr - rd_ptr (CW-bit subtraction).
- Write: mem[wr_ptr] <= data_in; wr_ptr+1.
- Read: rd_ptr+1.
- Both accepted: count unchanged, including at full, where the popped slot is refilled the same edge.
Error flags:
- overflow <= 1 when wr_en & !wr_acc.
- underflow <= 1 when rd_en & !rd_acc.
- Both hold until flush or rst. Successful operations do not clear them.
Status flags: full, empty, near_full, near_empty and count are combinational from the registered pointers, so they reflect an edge's update immediately after that edge.
FWFT=0 (standard read):
- On rd_acc: data_out <= mem[rd_ptr] and valid <= 1, appearing in the cycle after the rd_en edge (1-cycle latency).
- Otherwise valid <= 0 and data_out holds its last value.
FWFT=1 (fall-through):
- valid = !empty (combinational).
- data_out = mem[rd_ptr] whenever valid, else 0.
- rd_en acts as the pop; the next word appears the cycle after the pop edge.
- A word written into an empty FIFO appears on data_out the cycle after its write edge (write-to-read latency 1).
Boundary conditions:
- Pointer wrap: correct ordering across the 2*DEPTH pointer rollover, with no glitch on full or empty.
- Reset asserted mid-burst clears all state within the same cycle. The first write after rst deasserts lands at mem[0].

Test Plan:
1. FWFT=0, DEPTH=8, WIDTH=8: write 0x01..0x08 on consecutive cycles -> full=1, count=8, near_full was 1 at count 6,7; 9th write 0xFF -> overflow=1, count stays 8; read 8 -> data_out 0x01..0x08 each one cycle after rd_en with valid=1; then empty=1, 0xFF never appears.
2. Full + simultaneous wr_en/rd_en with data_in 0xAA -> count stays 8, overflow stays 0, 0xAA read out after the 7 remaining originals.
3. Empty, rd_en=1 with wr_en=1 data_in 0x55 -> underflow=1, valid=0 next cycle, count=1; next read returns 0x55.
4. Run 40 write/read pairs with incrementing data, crossing both pointer wraps -> output sequence identical to input, count never exceeds 8, no spurious flags.
5. FWFT=1: write 0x3C into empty FIFO -> next cycle valid=1, data_out=0x3C before any rd_en; pop -> valid=0, data_out=0.
6. Fill to 5 with overflow=1 set, then pulse flush -> count=0, empty=1, overflow=0; assert rst low mid-burst -> all outputs 0 asynchronously; after release, write 0x77 and read it back as 0x77.

Source files
------------

// File: rtl/sync_fifo_gen2.sv
// Single-clock FIFO that uses all DEPTH entries, with standard or fall-through read mode.
// Its overflow and underflow flags stay set until a flush or a reset clears them.
module sync_fifo_gen2 #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int FWFT   = 0,
  parameter int NEAR_E = 2,
  parameter int NEAR_F = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           data_in,
  input  logic                       wr_en,
  input  logic                       rd_en,
  input  logic                       flush,
  output logic [WIDTH-1:0]           data_out,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       near_full,
  output logic                       empty,
  output logic                       near_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] NF_LO_C  = CW'(DEPTH - NEAR_F);
  localparam logic [CW-1:0] NF_HI_C  = CW'(DEPTH - 1);
  localparam logic [CW-1:0] NE_HI_C  = CW'(NEAR_E);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          overflow_reg, underflow_reg;
  logic          rd_acc, wr_acc;
  logic [WIDTH-1:0] head_word;

  // The extra pointer bit separates full (count == DEPTH) from empty (count == 0).
  assign count      = wr_ptr_reg - rd_ptr_reg;
  assign full       = (count == DEPTH_C);
  assign empty      = (count == '0);
  assign near_full  = (count >= NF_LO_C) && (count <= NF_HI_C);
  assign near_empty = (count >= ONE_C) && (count <= NE_HI_C);
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

  // There is no bypass path, so a read while empty is rejected even when a write arrives in the same cycle.
  assign rd_acc = rd_en & ~empty;
  assign wr_acc = wr_en & (~full | rd_acc);

  assign head_word = mem[rd_ptr_reg[AW-1:0]];

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (wr_acc) wr_ptr_next = wr_ptr_reg + ONE_C;
      if (rd_acc) rd_ptr_next = rd_ptr_reg + ONE_C;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      if (flush) begin
        overflow_reg  <= 1'b0;
        underflow_reg <= 1'b0;
      end else begin
        if (wr_en && !wr_acc) overflow_reg  <= 1'b1;
        if (rd_en && !rd_acc) underflow_reg <= 1'b1;
      end
    end
  end

  // The storage array has no reset, so synthesis can map it onto RAM.
  always_ff @(posedge clk) begin
    if (rst && wr_acc && !flush) mem[wr_ptr_reg[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] data_out_reg;
      logic             valid_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else if (flush) begin
          data_out_reg <= '0;
          valid_reg    <= 1'b0;
        end else if (rd_acc) begin
          data_out_reg <= head_word;
          valid_reg    <= 1'b1;
        end else begin
          valid_reg    <= 1'b0;
        end
      end

      assign data_out = data_out_reg;
      assign valid    = valid_reg;
    end else begin : g_fwft
      // The head word is presented directly from the array, so a popped word is replaced on the next cycle.
      assign valid    = ~empty;
      assign data_out = empty ? '0 : head_word;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_gen2.sv
// Directed bench for sync_fifo_gen2. One standard-read instance and one fall-through instance share the clock and the reset.
module tb_sync_fifo_gen2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;

  logic [7:0] a_din = '0, b_din = '0;
  logic       a_wr = 1'b0, a_rd = 1'b0, a_fl = 1'b0;
  logic       b_wr = 1'b0, b_rd = 1'b0, b_fl = 1'b0;

  logic [7:0] a_dout, b_dout;
  logic       a_valid, b_valid;
  logic [3:0] a_count, b_count;
  logic       a_full, a_nfull, a_empty, a_nempty, a_ovf, a_unf;
  logic       b_full, b_nfull, b_empty, b_nempty, b_ovf, b_unf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_gen2 #(.WIDTH(8), .DEPTH(8), .FWFT(0), .NEAR_E(2), .NEAR_F(2)) dut_std (
    .clk(clk), .rst(rst), .data_in(a_din), .wr_en(a_wr), .rd_en(a_rd), .flush(a_fl),
    .data_out(a_dout), .valid(a_valid), .count(a_count), .full(a_full),
    .near_full(a_nfull), .empty(a_empty), .near_empty(a_nempty),
    .overflow(a_ovf), .underflow(a_unf)
  );

  sync_fifo_gen2 #(.WIDTH(8), .DEPTH(8), .FWFT(1), .NEAR_E(2), .NEAR_F(2)) dut_fwft (
    .clk(clk), .rst(rst), .data_in(b_din), .wr_en(b_wr), .rd_en(b_rd), .flush(b_fl),
    .data_out(b_dout), .valid(b_valid), .count(b_count), .full(b_full),
    .near_full(b_nfull), .empty(b_empty), .near_empty(b_nempty),
    .overflow(b_ovf), .underflow(b_unf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Both instances are held in reset, and every output should read zero (FWFT empty reads as zero).
    #12;
    check("rst_count", 32'(a_count), 0);
    check("rst_empty", 32'(a_empty), 1);
    check("rst_valid", 32'(a_valid), 0);
    check("rst_dout", 32'(a_dout), 0);
    check("rst_fwft_valid", 32'(b_valid), 0);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: fill with 0x01..0x08 and check near_full at counts 6 and 7.
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_din = 8'(i + 1);
      step();
      $display("t1 write %02h count=%0d nfull=%0d", a_din, a_count, a_nfull);
      check("t1_count", 32'(a_count), 32'(i + 1));
      check("t1_nfull", 32'(a_nfull), (i + 1 == 6 || i + 1 == 7) ? 1 : 0);
      check("t1_nempty", 32'(a_nempty), (i + 1 <= 2) ? 1 : 0);
    end
    check("t1_full", 32'(a_full), 1);
    a_din = 8'hFF;
    step();
    $display("t1 overflow write ff count=%0d ovf=%0d", a_count, a_ovf);
    check("t1_ovf", 32'(a_ovf), 1);
    check("t1_count_full", 32'(a_count), 8);
    a_wr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a_rd = 1'b1;
      step();
      $display("t1 read %02h valid=%0d", a_dout, a_valid);
      check("t1_rdata", 32'(a_dout), 32'(i + 1));
      check("t1_rvalid", 32'(a_valid), 1);
    end
    a_rd = 1'b0;
    step();
    check("t1_empty", 32'(a_empty), 1);
    check("t1_valid_off", 32'(a_valid), 0);
    check("t1_hold", 32'(a_dout), 8);

    // A flush clears the sticky overflow.
    a_fl = 1'b1;
    step();
    a_fl = 1'b0;
    $display("flush ovf=%0d count=%0d", a_ovf, a_count);
    check("fl_ovf", 32'(a_ovf), 0);
    check("fl_count", 32'(a_count), 0);

    // Test 2: while full, a simultaneous write and read keeps count at 8 and is not an overflow.
    for (int i = 0; i < 8; i++) begin
      a_wr = 1'b1; a_din = 8'(8'h11 + i);
      step();
    end
    a_rd = 1'b1; a_din = 8'hAA;
    step();
    a_wr = 1'b0;
    $display("t2 wr+rd at full count=%0d ovf=%0d dout=%02h", a_count, a_ovf, a_dout);
    check("t2_count", 32'(a_count), 8);
    check("t2_ovf", 32'(a_ovf), 0);
    check("t2_first", 32'(a_dout), 32'h11);
    for (int i = 0; i < 8; i++) begin
      step();
      $display("t2 read %02h", a_dout);
      check("t2_rdata", 32'(a_dout), (i == 7) ? 32'hAA : 32'(8'h12 + i));
    end
    a_rd = 1'b0;
    check("t2_empty", 32'(a_empty), 1);

    // Test 3: a read while empty is rejected even when a write arrives in the same cycle.
    a_wr = 1'b1; a_rd = 1'b1; a_din = 8'h55;
    step();
    a_wr = 1'b0;
    $display("t3 rd+wr on empty unf=%0d valid=%0d count=%0d", a_unf, a_valid, a_count);
    check("t3_unf", 32'(a_unf), 1);
    check("t3_valid", 32'(a_valid), 0);
    check("t3_count", 32'(a_count), 1);
    step();
    a_rd = 1'b0;
    $display("t3 read %02h", a_dout);
    check("t3_rdata", 32'(a_dout), 32'h55);
    check("t3_rvalid", 32'(a_valid), 1);

    // Test 4: 40 streaming write/read pairs carry the pointers past both wrap points.
    a_fl = 1'b1;
    step();
    a_fl = 1'b0;
    a_wr = 1'b1; a_din = 8'h00;
    step();
    for (int i = 1; i <= 40; i++) begin
      a_rd = 1'b1; a_din = 8'(i);
      step();
      $display("t4 pair %0d read %02h count=%0d", i, a_dout, a_count);
      check("t4_rdata", 32'(a_dout), 32'(i - 1));
      check("t4_count", 32'(a_count), 1);
    end
    a_wr = 1'b0;
    step();
    a_rd = 1'b0;
    check("t4_last", 32'(a_dout), 40);
    check("t4_empty", 32'(a_empty), 1);
    check("t4_ovf", 32'(a_ovf), 0);
    check("t4_unf", 32'(a_unf), 0);

    // Test 5: in fall-through mode a word shows on data_out the cycle after it is written.
    check("t5_init_valid", 32'(b_valid), 0);
    b_wr = 1'b1; b_din = 8'h3C;
    step();
    b_wr = 1'b0;
    $display("t5 fwft valid=%0d dout=%02h", b_valid, b_dout);
    check("t5_valid", 32'(b_valid), 1);
    check("t5_dout", 32'(b_dout), 32'h3C);
    b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    $display("t5 pop valid=%0d dout=%02h", b_valid, b_dout);
    check("t5_pop_valid", 32'(b_valid), 0);
    check("t5_pop_dout", 32'(b_dout), 0);
    b_wr = 1'b1; b_din = 8'hA1;
    step();
    b_din = 8'hA2;
    step();
    b_wr = 1'b0; b_rd = 1'b1;
    step();
    b_rd = 1'b0;
    $display("t5 second head %02h", b_dout);
    check("t5_next_head", 32'(b_dout), 32'hA2);

    // Test 6: set overflow, drop to count 5, flush, then apply an asynchronous reset mid-burst.
    a_wr = 1'b1;
    for (int i = 0; i < 9; i++) begin
      a_din = 8'(8'h30 + i);
      step();
    end
    a_wr = 1'b0; a_rd = 1'b1;
    for (int i = 0; i < 3; i++) step();
    a_rd = 1'b0;
    check("t6_count5", 32'(a_count), 5);
    check("t6_ovf_set", 32'(a_ovf), 1);
    a_fl = 1'b1;
    step();
    a_fl = 1'b0;
    $display("t6 flush count=%0d empty=%0d ovf=%0d", a_count, a_empty, a_ovf);
    check("t6_fl_count", 32'(a_count), 0);
    check("t6_fl_empty", 32'(a_empty), 1);
    check("t6_fl_ovf", 32'(a_ovf), 0);
    a_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_din = 8'(8'h60 + i);
      step();
    end
    a_rd = 1'b1; a_din = 8'h63;
    step();
    check("t6_pre_rst_dout", 32'(a_dout), 32'h60);
    #2;
    rst = 1'b0;
    #1;
    $display("t6 async rst count=%0d dout=%02h valid=%0d", a_count, a_dout, a_valid);
    check("t6_rst_count", 32'(a_count), 0);
    check("t6_rst_dout", 32'(a_dout), 0);
    check("t6_rst_valid", 32'(a_valid), 0);
    check("t6_rst_empty", 32'(a_empty), 1);
    check("t6_rst_fwft_count", 32'(b_count), 0);
    a_wr = 1'b0; a_rd = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    a_wr = 1'b1; a_din = 8'h77;
    step();
    a_wr = 1'b0; a_rd = 1'b1;
    step();
    a_rd = 1'b0;
    $display("t6 after reset read %02h", a_dout);
    check("t6_post_rdata", 32'(a_dout), 32'h77);
    check("t6_post_empty", 32'(a_empty), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
